// File: rtl/voice_flap_detector_if.sv
// voice_flap_detector_if: codec sample/threshold inputs and flap/level outputs of the voice flap detector
interface voice_flap_detector_if;
  logic        read_ready_true;
  logic [23:0] readdata_left;
  logic [23:0] readdata_right;
  logic [23:0] threshold;
  logic        read;
  logic        flap;
  logic [23:0] level;
  logic        holdoff;
  modport master (
    output read_ready_true, readdata_left, readdata_right, threshold,
    input  read, flap, level, holdoff
  );
  modport slave (
    input  read_ready_true, readdata_left, readdata_right, threshold,
    output read, flap, level, holdoff
  );
endinterface

// File: rtl/voice_flap_detector.sv
// voice_flap_detector: windowed mean |audio| level with thresholded one-shot flap and hold-off.
// Optional FLAP_HYSTERESIS_EN: REARM waits for a window below threshold/2 before re-arming.
module voice_flap_detector #(
  parameter int WIN_LOG2     = 8,
  parameter int HOLD_WINDOWS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  voice_flap_detector_if.slave bus
);
  typedef enum logic [1:0] {ARMED, FIRE, HOLDOFF, REARM} state_t;
  state_t                r_state;
  logic [1:0]            r_blk;
  logic                  r_read, r_mix_v, r_wend, r_flap, r_holdoff;
  logic [23:0]           r_l, r_r, r_mix, r_level, r_thr;
  logic [WIN_LOG2-1:0]   r_cnt;
  logic [23+WIN_LOG2:0]  r_acc;
  logic [7:0]            r_hold;
  logic                  w_take, w_last;
  logic [24:0]           w_sum;
  logic [23:0]           w_mix;
  logic [23+WIN_LOG2:0]  w_acc_next;

  function automatic logic [23:0] mag(input logic [23:0] s);
    return s[23] ? ((s == 24'h800000) ? 24'h7FFFFF : -s) : s;
  endfunction

  assign w_take     = bus.read_ready_true && (r_blk == 2'd0);
  assign w_sum      = {1'b0, mag(r_l)} + {1'b0, mag(r_r)};
  assign w_mix      = 24'(w_sum >> 1);
  assign w_acc_next = r_acc + {{WIN_LOG2{1'b0}}, r_mix};
  assign w_last     = (r_cnt == '1);

  // capture -> mix -> accumulate pipeline; blackout spans the read cycle and the one after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_read  <= 1'b0;
      r_l     <= '0;
      r_r     <= '0;
      r_mix   <= '0;
      r_mix_v <= 1'b0;
      r_wend  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_level <= '0;
      r_thr   <= '0;
    end else begin
      r_read  <= w_take;
      r_blk   <= w_take ? 2'd2 : ((r_blk != 2'd0) ? r_blk - 2'd1 : 2'd0);
      if (w_take) begin
        r_l <= bus.readdata_left;
        r_r <= bus.readdata_right;
      end
      r_mix_v <= r_read;
      if (r_read) r_mix <= w_mix;
      r_wend  <= r_mix_v && w_last;
      if (r_mix_v) begin
        r_cnt <= r_cnt + WIN_LOG2'(1);
        r_acc <= w_last ? '0 : w_acc_next;
        if (w_last) begin
          r_level <= 24'(w_acc_next >> WIN_LOG2);
          r_thr   <= bus.threshold;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARMED;
      r_flap    <= 1'b0;
      r_holdoff <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_flap <= 1'b0;
      case (r_state)
        ARMED: if (r_wend && (r_level > r_thr)) begin
          r_state <= FIRE;
          r_flap  <= 1'b1;
        end
        FIRE: begin
          r_state   <= HOLDOFF;
          r_hold    <= 8'(HOLD_WINDOWS);
          r_holdoff <= 1'b1;
        end
        HOLDOFF: if (r_wend) begin
          r_hold <= r_hold - 8'd1;
          if (r_hold == 8'd1) r_state <= REARM;
        end
        REARM: begin
`ifdef FLAP_HYSTERESIS_EN
          if (r_wend && (r_level < {1'b0, r_thr[23:1]})) begin
            r_state   <= ARMED;
            r_holdoff <= 1'b0;
          end
`else
          r_state   <= ARMED;
          r_holdoff <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.read    = r_read;
  assign bus.flap    = r_flap;
  assign bus.level   = r_level;
  assign bus.holdoff = r_holdoff;
endmodule

// File: tb/tb_voice_flap_detector.sv
// tb_voice_flap_detector: directed windows; expected level/flap/holdoff queued per window, checked by a read-driven monitor
module tb_voice_flap_detector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voice_flap_detector_if bus ();
  voice_flap_detector #(.WIN_LOG2(2), .HOLD_WINDOWS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {logic [23:0] level; logic flap; logic hold;} exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int flaps = 0;
  int rcnt = 0;
  logic [4:0] sh = '0;
  logic [11:0] pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // window end is the 4th read since reset; level at +2, flap at +3, holdoff at +4 cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      sh = '0;
      rcnt = 0;
    end else begin
      sh = {sh[3:0], bus.read && (rcnt == 3)};
      if (bus.read) rcnt = (rcnt + 1) % 4;
      if (sh[2]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL window_end unexpected level=%h", bus.level);
        end else begin
          cur = q.pop_front();
          chk("level", 32'(bus.level), 32'(cur.level));
        end
      end
      if (sh[3]) chk("flap", 32'(bus.flap), 32'(cur.flap));
      else if (bus.flap) begin
        checks++;
        errors++;
        $display("FAIL stray_flap actual=1 required=0 at %0t", $time);
      end
      if (sh[4]) chk("holdoff", 32'(bus.holdoff), 32'(cur.hold));
      if (bus.flap) flaps++;
    end
  end

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    bus.readdata_left = l;
    bus.readdata_right = r;
    bus.read_ready_true = 1'b1;
    @(posedge clk); #1;
    bus.read_ready_true = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic win(input logic [23:0] l, input logic [23:0] r, input logic [23:0] lv, input logic f, input logic h);
    q.push_back(exp_t'{lv, f, h});
    repeat (4) send(l, r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, 32'(bus.read), 0);
    chk({tag, "_flap"}, 32'(bus.flap), 0);
    chk({tag, "_level"}, 32'(bus.level), 0);
    chk({tag, "_holdoff"}, 32'(bus.holdoff), 0);
  endtask

  initial begin
    bus.read_ready_true = 1'b0;
    bus.readdata_left = '0;
    bus.readdata_right = '0;
    bus.threshold = 24'h001000;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(exp_t'{24'h0, 1'b0, 1'b0});
    bus.read_ready_true = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pat[i] = bus.read;
      @(posedge clk); #1;
    end
    bus.read_ready_true = 1'b0;
    chk("read_pattern", 32'(pat), 32'h492);
    repeat (4) @(posedge clk);
    #1;
    win(24'h002000, 24'hFFE000, 24'h002000, 1'b1, 1'b1);
    win(24'h0, 24'h0, 24'h0, 1'b0, 1'b1);
`ifdef FLAP_HYSTERESIS_EN
    win(24'h0, 24'h0, 24'h0, 1'b0, 1'b1);
    win(24'h0, 24'h0, 24'h0, 1'b0, 1'b0);
`else
    win(24'h0, 24'h0, 24'h0, 1'b0, 1'b0);
`endif
    win(24'h000FFF, 24'h000FFF, 24'h000FFF, 1'b0, 1'b0);
    q.push_back(exp_t'{24'h001000, 1'b0, 1'b0});
    send(24'h000800, 24'h000800);
    send(24'h000800, 24'h000800);
    send(24'h001800, 24'h001800);
    send(24'h001800, 24'h001800);
    win(24'h800000, 24'h800000, 24'h7FFFFF, 1'b1, 1'b1);
    win(24'h002000, 24'h002000, 24'h002000, 1'b0, 1'b1);
`ifdef FLAP_HYSTERESIS_EN
    win(24'h002000, 24'h002000, 24'h002000, 1'b0, 1'b1);
    win(24'h002000, 24'h002000, 24'h002000, 1'b0, 1'b1);
    win(24'h000800, 24'h000800, 24'h000800, 1'b0, 1'b1);
    win(24'h0007FF, 24'h0007FF, 24'h0007FF, 1'b0, 1'b0);
`else
    win(24'h002000, 24'h002000, 24'h002000, 1'b0, 1'b0);
`endif
    win(24'h002000, 24'h002000, 24'h002000, 1'b1, 1'b1);
    send(24'h0, 24'h0);
    send(24'h0, 24'h0);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("post_reset");
    win(24'h002000, 24'h002000, 24'h002000, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("flap_count", 32'(flaps), 32'd4);
    chk("queue_left", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
